// File: rtl/median_frame_ctrl_if.sv
// Pixel stream bundle between upstream source, frame sequencer and median filter.
// Handshake: a pixel transfers on a rising edge where in_valid & in_ready; gray has no back-pressure.
interface median_frame_ctrl_if;
  logic       in_valid;
  logic [7:0] in_pixel;
  logic       in_ready;
  logic       gray_valid;
  logic [7:0] gray;
  logic       median_valid;

  modport master (
    output in_valid, in_pixel, median_valid,
    input  in_ready, gray_valid, gray
  );

  modport slave (
    input  in_valid, in_pixel, median_valid,
    output in_ready, gray_valid, gray
  );
endinterface

// File: rtl/median_frame_ctrl.sv
// Frame sequencer for the 7x7 median filter: forwards one frame of pixels, pads
// four rows to flush the window and realign columns, drains, then pulses frame_done.
module median_frame_ctrl #(
  parameter int unsigned IMAGE_WIDTH  = 320,
  parameter int unsigned IMAGE_HEIGHT = 240,
  parameter logic [7:0]  PAD_VALUE    = 8'd0,
  parameter int unsigned DRAIN_CYCLES = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  median_frame_ctrl_if.slave bus,
  output logic               busy,
  output logic               frame_done,
  output logic [31:0]        med_count,
  output logic [2:0]         dbg_state
);

  localparam int unsigned FLUSH_LEN = 4 * IMAGE_WIDTH;
  localparam int unsigned CW = (IMAGE_WIDTH  > 1) ? $clog2(IMAGE_WIDTH)  : 1;
  localparam int unsigned RW = (IMAGE_HEIGHT > 1) ? $clog2(IMAGE_HEIGHT) : 1;
  localparam int unsigned FW = $clog2(FLUSH_LEN);
  localparam int unsigned DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  localparam logic [CW-1:0] COL_LAST   = CW'(IMAGE_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST   = RW'(IMAGE_HEIGHT - 1);
  localparam logic [FW-1:0] FLUSH_LAST = FW'(FLUSH_LEN - 1);
  localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RUN   = 3'd1,
    S_FLUSH = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic [FW-1:0] flush_cnt_q, flush_cnt_d;
  logic [DW-1:0] drain_cnt_q, drain_cnt_d;
  logic [31:0]   med_count_q, med_count_d;
  logic          gray_valid_q, gray_valid_d;
  logic [7:0]    gray_q, gray_d;
  logic          busy_q, busy_d;
  logic          frame_done_q, frame_done_d;
  logic          accept;

  assign accept = bus.in_valid && (state_q == S_RUN);

  always_comb begin
    state_d      = state_q;
    col_d        = col_q;
    row_d        = row_q;
    flush_cnt_d  = flush_cnt_q;
    drain_cnt_d  = drain_cnt_q;
    med_count_d  = med_count_q;
    gray_valid_d = 1'b0;
    gray_d       = gray_q;
    frame_done_d = 1'b0;

    if ((state_q != S_IDLE) && bus.median_valid) begin
      med_count_d = med_count_q + 32'd1;
    end

    case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          state_d     = S_RUN;
          col_d       = '0;
          row_d       = '0;
          flush_cnt_d = '0;
          drain_cnt_d = '0;
          med_count_d = '0;
        end
      end
      S_RUN: begin
        if (accept) begin
          gray_valid_d = 1'b1;
          gray_d       = bus.in_pixel;
          if (col_q == COL_LAST) begin
            col_d = '0;
            if (row_q == ROW_LAST) begin
              state_d = S_FLUSH;
            end else begin
              row_d = row_q + RW'(1);
            end
          end else begin
            col_d = col_q + CW'(1);
          end
        end
      end
      S_FLUSH: begin
        gray_valid_d = 1'b1;
        gray_d       = PAD_VALUE;
        if (flush_cnt_q == FLUSH_LAST) begin
          state_d = (DRAIN_CYCLES == 0) ? S_DONE : S_DRAIN;
        end else begin
          flush_cnt_d = flush_cnt_q + FW'(1);
        end
      end
      S_DRAIN: begin
        if (drain_cnt_q == DRAIN_LAST) begin
          state_d = S_DONE;
        end else begin
          drain_cnt_d = drain_cnt_q + DW'(1);
        end
      end
      S_DONE: begin
        state_d      = S_IDLE;
        frame_done_d = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    // Abort overrides everything: drop the pixel in flight and freeze the count.
    if (abort && (state_q != S_IDLE)) begin
      state_d      = S_IDLE;
      gray_valid_d = 1'b0;
      gray_d       = gray_q;
      frame_done_d = 1'b0;
      med_count_d  = med_count_q;
    end

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      col_q        <= '0;
      row_q        <= '0;
      flush_cnt_q  <= '0;
      drain_cnt_q  <= '0;
      med_count_q  <= '0;
      gray_valid_q <= 1'b0;
      gray_q       <= '0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      col_q        <= col_d;
      row_q        <= row_d;
      flush_cnt_q  <= flush_cnt_d;
      drain_cnt_q  <= drain_cnt_d;
      med_count_q  <= med_count_d;
      gray_valid_q <= gray_valid_d;
      gray_q       <= gray_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign bus.in_ready   = (state_q == S_RUN);
  assign bus.gray_valid = gray_valid_q;
  assign bus.gray       = gray_q;
  assign busy           = busy_q;
  assign frame_done     = frame_done_q;
  assign med_count      = med_count_q;
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_median_frame_ctrl.sv
// Randomized bench for median_frame_ctrl: per-cycle expectations come from a
// frame-level model (accept list, pad window, done edge, median_valid tally).
module tb_median_frame_ctrl;

  localparam int W      = 8;
  localparam int H      = 8;
  localparam int D      = 4;
  localparam int N      = W * H;
  localparam logic [7:0] PAD = 8'h5A;
  localparam int BUDGET = 1000;

  logic clk;
  logic rst;
  logic start;
  logic abort;
  logic in_valid;
  logic [7:0] in_pixel;
  logic median_valid;
  logic busy;
  logic frame_done;
  logic [31:0] med_count;
  logic [2:0] dbg_state;

  logic gray_valid;
  logic [7:0] gray;
  logic in_ready;

  int n_cmp;
  int n_err;

  logic [7:0] exp_q[$];
  bit         mv_hist[$];

  median_frame_ctrl_if bus_if ();

  assign bus_if.in_valid     = in_valid;
  assign bus_if.in_pixel     = in_pixel;
  assign bus_if.median_valid = median_valid;
  assign gray_valid          = bus_if.gray_valid;
  assign gray                = bus_if.gray;
  assign in_ready            = bus_if.in_ready;

  median_frame_ctrl #(
    .IMAGE_WIDTH  (W),
    .IMAGE_HEIGHT (H),
    .PAD_VALUE    (PAD),
    .DRAIN_CYCLES (D)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .abort      (abort),
    .bus        (bus_if.slave),
    .busy       (busy),
    .frame_done (frame_done),
    .med_count  (med_count),
    .dbg_state  (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One frame; called at #1 after a rising edge with the DUT idle.
  // abort_at / start_at: accept index at which abort / a stray start is driven (-1 = never).
  task automatic run_frame(input bit rand_valid, input int abort_at, input int start_at);
    int k, acc, last_acc, abort_edge, exp_done, stop_at, last_cnt;
    bit acc_now, exp_gv, exp_busy, exp_fd;
    logic [31:0] med_exp;
    exp_q.delete();
    mv_hist.delete();
    start = 1'b1;
    abort = 1'b0;
    in_valid = 1'b0;
    median_valid = 1'b0;
    mv_hist.push_back(1'b0);
    @(posedge clk); #1;
    start = 1'b0;
    k = 0; acc = 0; last_acc = -1; abort_edge = -1; exp_done = -1; acc_now = 1'b0;
    forever begin
      exp_gv   = acc_now || (last_acc >= 0 && k > last_acc && k <= last_acc + 4 * W);
      exp_busy = (abort_edge >= 0) ? (k < abort_edge) : (exp_done < 0 || k < exp_done);
      exp_fd   = (abort_edge < 0) && (k == exp_done);
      check_eq("gray_valid", 32'(gray_valid), 32'(exp_gv));
      if (exp_gv) check_eq("gray", 32'(gray), 32'(exp_q.pop_front()));
      check_eq("busy", 32'(busy), 32'(exp_busy));
      check_eq("frame_done", 32'(frame_done), 32'(exp_fd));
      check_eq("in_ready", 32'(in_ready), 32'(abort_edge < 0 && acc < N));
      stop_at = (abort_edge >= 0) ? abort_edge + 4 : ((exp_done >= 0) ? exp_done + 3 : -1);
      if (k == stop_at) break;
      if (k >= BUDGET) begin
        check_eq("timeout_frame_done", 32'(frame_done), 32'd1);
        break;
      end
      // stimulus for edge k+1
      acc_now = 1'b0;
      abort = 1'b0;
      start = 1'b0;
      in_valid = rand_valid ? 1'($urandom_range(0, 1)) : 1'b1;
      in_pixel = 8'($urandom_range(0, 255));
      median_valid = 1'($urandom_range(0, 1));
      if (abort_edge < 0 && acc < N) begin
        if (acc == abort_at) begin
          abort = 1'b1;
          abort_edge = k + 1;
          median_valid = 1'b0;
        end else begin
          if (acc == start_at) start = 1'b1;
          if (in_valid) begin
            acc_now = 1'b1;
            acc++;
            exp_q.push_back(in_pixel);
            if (acc == N) begin
              last_acc = k + 1;
              exp_done = last_acc + 4 * W + D + 1;
              repeat (4 * W) exp_q.push_back(PAD);
            end
          end
        end
      end
      mv_hist.push_back(median_valid);
      @(posedge clk); #1;
      k++;
    end
    start = 1'b0;
    abort = 1'b0;
    median_valid = 1'b0;
    in_valid = 1'b0;
    // median_valid counts on every edge whose preceding cycle was non-idle
    last_cnt = (abort_edge >= 0) ? abort_edge : exp_done;
    med_exp = 32'd0;
    for (int i = 1; i <= last_cnt && i < mv_hist.size(); i++) med_exp += 32'(mv_hist[i]);
    check_eq("med_count", med_count, med_exp);
    repeat (2) @(posedge clk);
    #1;
    check_eq("med_count_hold", med_count, med_exp);
    check_eq("idle_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    in_valid = 1'b0;
    in_pixel = 8'h00;
    median_valid = 1'b0;
    #12;
    check_eq("rst_in_ready", 32'(in_ready), 32'd0);
    check_eq("rst_gray_valid", 32'(gray_valid), 32'd0);
    check_eq("rst_gray", 32'(gray), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_frame_done", 32'(frame_done), 32'd0);
    check_eq("rst_med_count", med_count, 32'd0);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;

    run_frame(1'b0, -1, -1);   // nominal, in_valid held high
    run_frame(1'b1, -1, 10);   // random bubbles, stray start mid-RUN
    run_frame(1'b1, 20, -1);   // abort at accept 20
    run_frame(1'b0, -1, -1);   // full frame after abort

    // start and abort together in IDLE
    start = 1'b1;
    abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    abort = 1'b0;
    check_eq("race_busy", 32'(busy), 32'd0);
    check_eq("race_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    check_eq("race_busy_2", 32'(busy), 32'd0);

    // asynchronous reset while flushing
    start = 1'b1;
    in_valid = 1'b1;
    median_valid = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (N + 5) @(posedge clk);
    #1;
    check_eq("pre_rst_gray_valid", 32'(gray_valid), 32'd1);
    check_eq("pre_rst_gray", 32'(gray), 32'(PAD));
    check_eq("pre_rst_busy", 32'(busy), 32'd1);
    #2 rst = 1'b0;
    #1;
    check_eq("arst_busy", 32'(busy), 32'd0);
    check_eq("arst_gray_valid", 32'(gray_valid), 32'd0);
    check_eq("arst_in_ready", 32'(in_ready), 32'd0);
    check_eq("arst_med_count", med_count, 32'd0);
    check_eq("arst_frame_done", 32'(frame_done), 32'd0);
    median_valid = 1'b0;
    in_valid = 1'b0;
    @(negedge clk) rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_eq("post_rst_busy", 32'(busy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
